// File: rtl/imem_fetch_pkg.sv
// Shared constants, FSM encoding and address helpers for the instruction
// memory fetch block.
package imem_fetch_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // True when every byte-address bit above the word index is zero.
   function automatic logic in_range(input logic [31:0] byte_addr,
                                     input int unsigned idx_w);
      return (byte_addr >> (idx_w + 2)) == 32'd0;
   endfunction

endpackage

// File: rtl/imem_fetch_if.sv
// Fetch handshake, response and loader bundle between the IF stage
// (master) and the instruction memory (slave).
interface imem_fetch_if;
   logic        fetch_req;
   logic [31:0] fetch_pc;
   logic        fetch_ready;
   logic        stall;
   logic        flush;
   logic        rsp_valid;
   logic [31:0] rsp_instr;
   logic [31:0] rsp_pc;
   logic        rsp_fault;
   logic        prog_we;
   logic [31:0] prog_addr;
   logic [31:0] prog_wdata;
   logic        init_done;

   modport master (
      output fetch_req, fetch_pc, stall, flush, prog_we, prog_addr, prog_wdata,
      input  fetch_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault, init_done
   );

   modport slave (
      input  fetch_req, fetch_pc, stall, flush, prog_we, prog_addr, prog_wdata,
      output fetch_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault, init_done
   );
endinterface

// File: rtl/imem_ram.sv
// DEPTH x 32 instruction RAM: one synchronous read-first read port and one
// write port shared between the post-reset clear sequencer and the loader.
module imem_ram
   import imem_fetch_pkg::*;
#(
   parameter int          DEPTH = 256,
   parameter int          IDX_W = $clog2(DEPTH),
   parameter logic [31:0] NOP   = NOP_INSTR
) (
   input  logic             clk,
   input  logic             clear_en,
   input  logic [IDX_W-1:0] clear_idx,
   input  logic             ld_we,
   input  logic [IDX_W-1:0] ld_idx,
   input  logic [31:0]      ld_wdata,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [31:0]      rd_data
);

   logic [31:0]      mem [DEPTH];
   logic             we;
   logic [IDX_W-1:0] w_idx;
   logic [31:0]      w_data;

   // Clear sequencer owns the write port; the loader is only enabled in RUN.
   always_comb begin
      we     = clear_en | ld_we;
      w_idx  = clear_en ? clear_idx : ld_idx;
      w_data = clear_en ? NOP : ld_wdata;
   end

   // NOTE: no reset on the array -- it maps onto block RAM, and the clear
   // sequencer overwrites every word after reset instead.
   always_ff @(posedge clk) begin
      if (we)    mem[w_idx] <= w_data;
      if (rd_en) rd_data    <= mem[rd_idx];
   end

endmodule

// File: rtl/imem_fetch.sv
// RV32I IF-stage instruction memory: NOP clear sequencer, loader port,
// 1-cycle registered fetch with stall/flush and misaligned/range fault.
module imem_fetch
   import imem_fetch_pkg::*;
#(
   parameter int          DEPTH = 256,
   parameter logic [31:0] NOP   = NOP_INSTR
) (
   input logic         clk,
   input logic         rst,
   imem_fetch_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] cnt_q;
   logic             clear_en, run, held, ready, accept, pc_fault, ld_we;
   logic             rsp_valid_q, rsp_fault_q, from_ram_q;
   logic [31:0]      rsp_pc_q, ram_rdata;

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_CLEAR;
      else      state_q <= state_d;
   end

   // NOTE: defaults first, so no path through the case can infer a latch.
   always_comb begin
      state_d  = state_q;
      clear_en = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            clear_en = 1'b1;
            if (cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
         end
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          cnt_q <= '0;
      else if (clear_en) cnt_q <= cnt_q + IDX_W'(1);
   end

   assign run      = (state_q == ST_RUN);
   assign held     = rsp_valid_q && bus.stall && !bus.flush;
   assign ready    = run && !held;
   assign accept   = bus.fetch_req && ready;
   assign pc_fault = (bus.fetch_pc[1:0] != 2'b00) || !in_range(bus.fetch_pc, IDX_W);
   assign ld_we    = bus.prog_we && run && in_range(bus.prog_addr, IDX_W);

   imem_ram #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NOP(NOP)) u_ram (
      .clk       (clk),
      .clear_en  (clear_en),
      .clear_idx (cnt_q),
      .ld_we     (ld_we),
      .ld_idx    (bus.prog_addr[IDX_W+1:2]),
      .ld_wdata  (bus.prog_wdata),
      .rd_en     (accept && !pc_fault),
      .rd_idx    (bus.fetch_pc[IDX_W+1:2]),
      .rd_data   (ram_rdata)
   );

   // from_ram_q selects the RAM output; faults and reset present NOP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid_q <= 1'b0;
         rsp_pc_q    <= '0;
         rsp_fault_q <= 1'b0;
         from_ram_q  <= 1'b0;
      end else if (accept) begin
         rsp_valid_q <= 1'b1;
         rsp_pc_q    <= bus.fetch_pc;
         rsp_fault_q <= pc_fault;
         from_ram_q  <= !pc_fault;
      end else if (!held) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign bus.fetch_ready = ready;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_instr   = from_ram_q ? ram_rdata : NOP;
   assign bus.rsp_pc      = rsp_pc_q;
   assign bus.rsp_fault   = rsp_fault_q;
   assign bus.init_done   = run;

endmodule
